// File: rtl/fpu_issue_ctrl_if.sv
// Command, response and FPU-side signals of the FPU issue controller.
// master = controller side, slave = pipeline/CSR and FPU environment side.
interface fpu_issue_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [1:0]  cmd_mode;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_s;
    logic [3:0]  rsp_flags;
    logic        rsp_timeout;
    logic        busy;

    logic        fpu_start;
    logic [1:0]  fpu_mode;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_s;
    logic        fpu_zero;
    logic        fpu_nan;
    logic        fpu_inf;
    logic        fpu_error;
    logic        fpu_ready;
    logic        fpu_done;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_mode, rsp_ready,
        input  fpu_s, fpu_zero, fpu_nan, fpu_inf, fpu_error, fpu_ready, fpu_done,
        output cmd_ready, rsp_valid, rsp_s, rsp_flags, rsp_timeout, busy,
        output fpu_start, fpu_mode, fpu_a, fpu_b
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_mode, rsp_ready,
        output fpu_s, fpu_zero, fpu_nan, fpu_inf, fpu_error, fpu_ready, fpu_done,
        input  cmd_ready, rsp_valid, rsp_s, rsp_flags, rsp_timeout, busy,
        input  fpu_start, fpu_mode, fpu_a, fpu_b
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: FIFO-buffered commands issued one at a time over start/ready/done; WAIT timeout via FPU_ISSUE_TIMEOUT_EN.
// Latency: command accept -> fpu_start 2 cycles; fpu_done -> rsp_valid 1 cycle.
// Backpressure: cmd_ready drops at DEPTH entries (no same-cycle bypass); response held until rsp_ready.
module fpu_issue_ctrl #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input logic              clk_i,
    input logic              rst_ni,
    fpu_issue_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_cfg_check
        $error("fpu_issue_ctrl: DEPTH must be a power of 2 >= 2, TIMEOUT_CYC >= 1");
    end

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          push;
    logic          pop;
    logic          idle_nxt;
    state_t        state;

    assign push     = bus.cmd_valid && bus.cmd_ready;
    assign pop      = (state == IDLE) && (count != '0) && bus.fpu_ready;
    assign head     = mem[rd_ptr];
    assign idle_nxt = ((state == IDLE) && !pop) || ((state == RESP) && bus.rsp_ready);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{mode: bus.cmd_mode, a: bus.cmd_a, b: bus.cmd_b};
        end
    end

    // cmd_ready follows the registered occupancy, so a full FIFO refuses a push even while popping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.cmd_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count         <= count_nxt;
            bus.cmd_ready <= (count_nxt != (AW + 1)'(DEPTH));
        end
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_hit = (wait_cnt == TW'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            bus.fpu_start   <= 1'b0;
            bus.fpu_mode    <= '0;
            bus.fpu_a       <= '0;
            bus.fpu_b       <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_s       <= '0;
            bus.rsp_flags   <= '0;
            bus.rsp_timeout <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.busy <= !idle_nxt || (count_nxt != '0);
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.fpu_mode  <= head.mode;
                        bus.fpu_a     <= head.a;
                        bus.fpu_b     <= head.b;
                        bus.fpu_start <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    bus.fpu_start <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (bus.fpu_done) begin
                        bus.rsp_s       <= bus.fpu_s;
                        bus.rsp_flags   <= {bus.fpu_error, bus.fpu_inf, bus.fpu_nan, bus.fpu_zero};
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end
`ifdef FPU_ISSUE_TIMEOUT_EN
                    else if (timeout_hit) begin
                        bus.rsp_s       <= '0;
                        bus.rsp_flags   <= 4'b1000;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
